ks_adder_pipe: RTL and testbench

- Parametrised, pipelined Kogge-Stone adder/subtractor with a valid/ready handshake on both sides.
- Generalises the fixed 16-bit combinational prefix layers to any WIDTH.
- Registers every prefix level and sustains one operation per clock.
- Sits in the datapath wherever a wide, high-fmax add or subtract is needed.

---
 rtl/ks_pkg.sv | 19 +
 rtl/ks_prefix_level.sv | 55 +++++
 rtl/ks_adder_pipe.sv | 123 ++++++++++++
 tb/tb_ks_adder_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder.
//   ks_levels(width)     : number of prefix levels (clog2 of the width)
//   ks_dist(level)       : combine distance of prefix level 1..LEVELS
//   ks_out_stage(levels) : index of the result stage in the valid pipe
package ks_pkg;

    function automatic int ks_levels(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

    function automatic int ks_dist(input int level);
        return 1 << (level - 1);
    endfunction

    function automatic int ks_out_stage(input int levels);
        return levels + 1;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One registered Kogge-Stone prefix level.
// Works on the carry-extended vectors (bit 0 holds the carry-in as G[-1]),
// so g/p are WIDTH+1 bits wide.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   en              global pipe enable; when low every register holds
//   src_vld/vld     stage valid bit in / registered out
//   src_g, src_p    group generate/propagate from the previous level
//   src_po, po      original (level-0) propagate, carried for the sum stage
//   g, p            combined group generate/propagate, registered
module ks_prefix_level #(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             src_vld,
    input  logic [WIDTH:0]   src_g,
    input  logic [WIDTH:0]   src_p,
    input  logic [WIDTH-1:0] src_po,
    output logic             vld,
    output logic [WIDTH:0]   g,
    output logic [WIDTH:0]   p,
    output logic [WIDTH-1:0] po
);

    logic [WIDTH:0] g_nxt;
    logic [WIDTH:0] p_nxt;

    // Bits below DIST already span down to the carry-in; they pass through.
    always_comb begin
        g_nxt = src_g;
        p_nxt = src_p;
        for (int i = DIST; i <= WIDTH; i++) begin
            g_nxt[i] = src_g[i] | (src_p[i] & src_g[i-DIST]);
            p_nxt[i] = src_p[i] & src_p[i-DIST];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            g   <= '0;
            p   <= '0;
            po  <= '0;
        end else if (en) begin
            vld <= src_vld;
            g   <= g_nxt;
            p   <= p_nxt;
            po  <= src_po;
        end
    end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor, one operation per clock.
// Stages: S0 (operand capture, P/G generate), LEVELS prefix levels, S_out.
// The whole pipe advances together on en = !out_valid | out_ready; a stall
// freezes every stage, bubbles included.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           operand handshake (in_ready = en)
//   in_a, in_b, in_cin, in_sub  operands; in_sub=1 gives A-B, cin ignored
//   out_valid/out_ready         result handshake
//   out_sum, out_cout, out_ovf  result, carry (1 = no borrow on subtract),
//                               signed overflow
module ks_adder_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int LEVELS    = ks_levels(WIDTH);
    localparam int OUT_STAGE = ks_out_stage(LEVELS);

    logic                        en;
    logic [OUT_STAGE:0]          vld_pipe;
    logic [LEVELS:0][WIDTH:0]    g_pipe;
    logic [LEVELS:0][WIDTH:0]    p_pipe;
    logic [LEVELS:0][WIDTH-1:0]  po_pipe;

    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign b_eff = in_sub ? ~in_b : in_b;
    assign c0    = in_sub | in_cin;

    // S0: generate P/G; the carry-in sits at extended bit 0 as G[-1] (P=0).
    logic             s0_vld;
    logic [WIDTH:0]   s0_g;
    logic [WIDTH:0]   s0_p;
    logic [WIDTH-1:0] s0_po;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld <= 1'b0;
            s0_g   <= '0;
            s0_p   <= '0;
            s0_po  <= '0;
        end else if (en) begin
            s0_vld <= in_valid;
            s0_g   <= {in_a & b_eff, c0};
            s0_p   <= {in_a ^ b_eff, 1'b0};
            s0_po  <= in_a ^ b_eff;
        end
    end

    assign vld_pipe[0] = s0_vld;
    assign g_pipe[0]   = s0_g;
    assign p_pipe[0]   = s0_p;
    assign po_pipe[0]  = s0_po;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        ks_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (ks_dist(k))
        ) u_lvl (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .src_vld (vld_pipe[k-1]),
            .src_g   (g_pipe[k-1]),
            .src_p   (p_pipe[k-1]),
            .src_po  (po_pipe[k-1]),
            .vld     (vld_pipe[k]),
            .g       (g_pipe[k]),
            .p       (p_pipe[k]),
            .po      (po_pipe[k])
        );
    end

    assign vld_pipe[OUT_STAGE] = out_valid;

    // Extended bit i holds the carry into operand bit i. The top bit only
    // spans down to bit 1 when WIDTH is a power of two, so the carry-in
    // (extended bit 0, never modified) gets one last combine for cout.
    logic [WIDTH:0] gf;
    logic [WIDTH:0] pf;
    logic           cout_nxt;
    logic           pf_unused;

    assign gf        = g_pipe[LEVELS];
    assign pf        = p_pipe[LEVELS];
    assign cout_nxt  = gf[WIDTH] | (pf[WIDTH] & gf[0]);
    assign pf_unused = ^pf[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (en) begin
            out_valid <= vld_pipe[LEVELS];
            out_sum   <= po_pipe[LEVELS] ^ gf[WIDTH-1:0];
            out_cout  <= cout_nxt;
            out_ovf   <= gf[WIDTH-1] ^ cout_nxt;
        end
    end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Self-checking bench: three instances (WIDTH 16, 13, 32) driven in lockstep
// with shared handshake controls and per-instance random operands, checked
// against an arithmetic reference model through per-instance scoreboards.
module tb_ks_adder_pipe;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    int wid [3] = '{16, 13, 32};

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_cin;
    logic        in_sub;
    logic        out_ready;
    logic [63:0] ta [3];
    logic [63:0] tb [3];
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_cout;
    logic [2:0]  out_ovf;
    logic [15:0] s0;
    logic [12:0] s1;
    logic [31:0] s2;
    logic [63:0] osum [3];

    int checks = 0;
    int errors = 0;
    int pushes [3] = '{0, 0, 0};
    int pops   [3] = '{0, 0, 0};
    res_t q0 [$];
    res_t q1 [$];
    res_t q2 [$];

    assign osum[0] = 64'(s0);
    assign osum[1] = 64'(s1);
    assign osum[2] = 64'(s2);

    ks_adder_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_a(ta[0][15:0]), .in_b(tb[0][15:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_sum(s0),
        .out_cout(out_cout[0]), .out_ovf(out_ovf[0]));

    ks_adder_pipe #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_a(ta[1][12:0]), .in_b(tb[1][12:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_sum(s1),
        .out_cout(out_cout[1]), .out_ovf(out_ovf[1]));

    ks_adder_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_a(ta[2][31:0]), .in_b(tb[2][31:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_sum(s2),
        .out_cout(out_cout[2]), .out_ovf(out_ovf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned result/carry from plain integer arithmetic, signed
    // overflow from whether the true signed result fits in WIDTH bits.
    function automatic res_t model(int w, logic [63:0] a, logic [63:0] b,
                                   logic cin, logic sub);
        res_t r;
        logic [63:0] mask;
        longint unsigned ua, ub, uv;
        longint sa, sb, sv, smax, smin;
        mask = (64'd1 << w) - 64'd1;
        ua = a & mask;
        ub = b & mask;
        sa = longint'(ua);
        sb = longint'(ub);
        if (ua[w-1]) sa = sa - longint'(64'd1 << w);
        if (ub[w-1]) sb = sb - longint'(64'd1 << w);
        smax = longint'(64'd1 << (w - 1)) - 1;
        smin = -longint'(64'd1 << (w - 1));
        if (sub) begin
            uv     = ua - ub;
            r.cout = (ua >= ub);
            sv     = sa - sb;
        end else begin
            uv     = ua + ub + 64'(cin);
            r.cout = ((uv >> w) != 0);
            sv     = sa + sb + longint'(cin);
        end
        r.sum = uv & mask;
        r.ovf = (sv > smax) || (sv < smin);
        return r;
    endfunction

    function automatic int qsize(int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic res_t qpop(int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void qpush(int d, res_t r);
        case (d)
            0:       q0.push_back(r);
            1:       q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endfunction

    task automatic chk(string tag, int d, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s w%0d: observed 'h%0h expected 'h%0h", tag, wid[d], obs, exp);
        end
    endtask

    task automatic rand_ops();
        for (int d = 0; d < 3; d++) begin
            ta[d] = {$urandom, $urandom};
            tb[d] = {$urandom, $urandom};
        end
    endtask

    // One clock: settle, score both handshakes, then advance to the next negedge.
    task automatic tick();
        res_t r;
        #1;
        for (int d = 0; d < 3; d++) begin
            if (out_valid[d] && out_ready) begin
                pops[d]++;
                if (qsize(d) == 0) chk("spurious_out", d, 64'(out_valid[d]), 64'd0);
                else begin
                    r = qpop(d);
                    chk("sum",  d, osum[d], r.sum);
                    chk("cout", d, 64'(out_cout[d]), 64'(r.cout));
                    chk("ovf",  d, 64'(out_ovf[d]), 64'(r.ovf));
                end
            end
            if (in_valid && in_ready[d]) begin
                pushes[d]++;
                qpush(d, model(wid[d], ta[d], tb[d], in_cin, in_sub));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single beat, then measure accept-to-out_valid latency on every instance.
    task automatic send_measure(logic [63:0] a0, logic [63:0] b0, logic cin, logic sub,
                                logic chk_const, logic [15:0] es, logic ec, logic eo);
        int lat [3];
        int n;
        rand_ops();
        ta[0] = a0; tb[0] = b0;
        in_cin = cin; in_sub = sub; out_ready = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = '{0, 0, 0};
        n = 1;
        while (n <= 12) begin
            for (int d = 0; d < 3; d++) begin
                if (lat[d] == 0 && out_valid[d]) begin
                    lat[d] = n;
                    if (d == 0 && chk_const) begin
                        chk("dir_sum",  0, osum[0], 64'(es));
                        chk("dir_cout", 0, 64'(out_cout[0]), 64'(ec));
                        chk("dir_ovf",  0, 64'(out_ovf[0]), 64'(eo));
                    end
                end
            end
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
            tick();
            n++;
        end
        for (int d = 0; d < 3; d++) chk("latency", d, 64'(lat[d]), 64'($clog2(wid[d]) + 2));
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (n < 60 && (qsize(0) + qsize(1) + qsize(2)) > 0) begin
            tick();
            n++;
        end
        for (int k = 0; k < 3; k++) tick();
        for (int d = 0; d < 3; d++) begin
            chk("left_in_sb", d, 64'(qsize(d)), 64'd0);
            chk("push_pop",   d, 64'(pops[d]), 64'(pushes[d]));
        end
    endtask

    initial begin
        int first, last, cnt, n;
        logic [63:0] held;

        rst_n = 1'b0; in_valid = 1'b0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        rand_ops();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid", d, 64'(out_valid[d]), 64'd0);
            chk("rst_sum",   d, osum[d], 64'd0);
            chk("rst_cout",  d, 64'(out_cout[d]), 64'd0);
            chk("rst_ovf",   d, 64'(out_ovf[d]), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk("ready_after_rst", d, 64'(in_ready[d]), 64'd1);
        @(negedge clk);

        // Directed vectors on the 16-bit instance.
        send_measure(64'hFFFF, 64'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        send_measure(64'h7FFF, 64'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        send_measure(64'h1234, 64'h0000, 1'b1, 1'b0, 1'b1, 16'h1235, 1'b0, 1'b0);
        send_measure(64'h0005, 64'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send_measure(64'h8000, 64'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        drain();

        // Ten back-to-back beats; results must come out on ten consecutive cycles.
        out_ready = 1'b1;
        first = -1; last = -1; cnt = 0; n = 0;
        for (int i = 0; i < 30; i++) begin
            in_valid = (i < 10);
            in_sub = 1'($urandom); in_cin = 1'($urandom);
            rand_ops();
            if (out_valid[0]) begin
                if (first < 0) first = n;
                last = n;
                cnt++;
            end
            tick();
            n++;
        end
        chk("stream_count", 0, 64'(cnt), 64'd10);
        chk("stream_span",  0, 64'(last - first), 64'd9);
        drain();

        // Stall with a result parked at the output.
        out_ready = 1'b1;
        in_valid = 1'b1;
        n = 0;
        while (n < 20 && !out_valid[0]) begin
            rand_ops(); in_sub = 1'($urandom); in_cin = 1'($urandom);
            tick();
            n++;
        end
        chk("stall_reach", 0, 64'(out_valid[0]), 64'd1);
        held = osum[0];
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            tick();
            chk("stall_sum",   0, osum[0], held);
            chk("stall_valid", 0, 64'(out_valid[0]), 64'd1);
            chk("stall_ready", 0, 64'(in_ready[0]), 64'd0);
        end
        drain();

        // Reset with beats in flight (some already at the output).
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; rand_ops(); in_sub = 1'($urandom); in_cin = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk("rst_mid_valid", d, 64'(out_valid[d]), 64'd0);
        q0.delete(); q1.delete(); q2.delete();
        pushes = '{0, 0, 0}; pops = '{0, 0, 0};
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk("ready_after_rst2", d, 64'(in_ready[d]), 64'd1);
        @(negedge clk);
        send_measure({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                     1'b0, 16'h0, 1'b0, 1'b0);
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_sub = 1'($urandom); in_cin = 1'($urandom);
            rand_ops();
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
